// File: rtl/fp_div_pkg.sv
// Shared constants and state encoding for the mantissa divider.
package fp_div_pkg;

  // Fraction width of IEEE-754 single precision.
  localparam int unsigned FracWidth = 23;
  // Quotient width: one bit per dividend bit of {ma, (L+1)'b0}.
  localparam int unsigned QuotWidth = 2 * FracWidth + 2;
  // Iteration counter width.
  localparam int unsigned CntWidth  = $clog2(QuotWidth);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/fp_div_step.sv
// One restoring-division iteration: shift in a dividend bit, compare, conditionally subtract.
module fp_div_step #(
  parameter int unsigned L = 23
) (
  input  logic [L:0] r,
  input  logic       dbit,
  input  logic [L:0] mb,
  output logic [L:0] r_next,
  output logic       q_bit
);

  logic [L+1:0] t;

  // t < 2*mb always, so t - mb fits in L+1 bits and the truncated subtract is exact.
  always_comb begin
    t = {r, dbit};
    if (t >= {1'b0, mb}) begin
      r_next = t[L:0] - mb;
      q_bit  = 1'b1;
    end else begin
      r_next = t[L:0];
      q_bit  = 1'b0;
    end
  end

endmodule

// File: rtl/fp_mantissa_divider.sv
// Iterative radix-2 restoring mantissa divider, one quotient bit per clock.
module fp_mantissa_divider
  import fp_div_pkg::*;
#(
  parameter int unsigned L = fp_div_pkg::FracWidth
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [L:0]     ma,
  input  logic [L:0]     mb,
  output logic           busy,
  output logic           done,
  output logic [2*L+1:0] quotient,
  output logic [L:0]     remainder,
  output logic           sticky,
  output logic           div_by_zero
);

  localparam int unsigned Qw = 2 * L + 2;
  localparam int unsigned Cw = $clog2(Qw);
  localparam logic [Cw-1:0] LastCnt = Cw'(Qw - 1);

  state_e        state_q;
  logic [Cw-1:0] cnt_q;
  // Dividend significand; the low L+1 zero bits of D are shifted in behind it.
  logic [L:0]    dvd_q;
  logic [L:0]    div_q;
  // Partial remainder; its top bit is always zero after a step, so L+1 bits are stored.
  logic [L:0]    r_q;
  logic [L:0]    r_next;
  logic          q_bit;
  logic          accept;

  assign accept = start & ~busy;

  fp_div_step #(
    .L(L)
  ) u_step (
    .r     (r_q),
    .dbit  (dvd_q[L]),
    .mb    (div_q),
    .r_next(r_next),
    .q_bit (q_bit)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dvd_q       <= '0;
      div_q       <= '0;
      r_q         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      sticky      <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            if (mb == '0) begin
              state_q     <= StDone;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= '0;
              sticky      <= 1'b1;
              div_by_zero <= 1'b1;
            end else begin
              state_q     <= StRun;
              busy        <= 1'b1;
              r_q         <= '0;
              cnt_q       <= '0;
              dvd_q       <= ma;
              div_q       <= mb;
              quotient    <= '0;
              div_by_zero <= 1'b0;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          r_q      <= r_next;
          quotient <= {quotient[Qw-2:0], q_bit};
          dvd_q    <= {dvd_q[L-1:0], 1'b0};
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_q   <= StDone;
            busy      <= 1'b0;
            done      <= 1'b1;
            remainder <= r_next;
            sticky    <= |r_next;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mantissa_divider.sv
// Directed self-checking bench for fp_mantissa_divider.
module tb_fp_mantissa_divider;

  localparam int unsigned L = 23;

  logic          clk;
  logic          rst;
  logic          start;
  logic [L:0]    ma;
  logic [L:0]    mb;
  logic          busy;
  logic          done;
  logic [2*L+1:0] quotient;
  logic [L:0]    remainder;
  logic          sticky;
  logic          div_by_zero;

  int checks = 0;
  int errors = 0;

  fp_mantissa_divider #(
    .L(L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ma         (ma),
    .mb         (mb),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .sticky     (sticky),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an operation; returns #1 after the edge that samples start.
  task automatic launch(input logic [L:0] a, input logic [L:0] b);
    ma    = a;
    mb    = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges after the start edge until done; optionally poke start mid-run.
  task automatic wait_done(input string tag, input int exp_lat, input bit poke);
    int n;
    n = 0;
    while (!done && n < 200) begin
      if (poke && (n == 5 || n == 20)) begin
        start = 1'b1;
        ma    = 24'h800000;
        mb    = 24'hC00000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (n == 10) check({tag, " busy mid-run"}, 64'(busy), 64'd1);
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " busy at done"}, 64'(busy), 64'd0);
  endtask

  task automatic check_result(input string tag, input logic [2*L+1:0] q, input logic [L:0] rem,
                              input logic st, input logic dz);
    check({tag, " quotient"}, 64'(quotient), 64'(q));
    check({tag, " remainder"}, 64'(remainder), 64'(rem));
    check({tag, " sticky"}, 64'(sticky), 64'(st));
    check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(dz));
  endtask

  initial begin
    int seen;
    rst   = 1'b1;
    start = 1'b0;
    ma    = '0;
    mb    = '0;
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check_result("reset", '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1.0 / 1.0
    launch(24'h800000, 24'h800000);
    wait_done("one_by_one", 48, 1'b0);
    check_result("one_by_one", 48'h000001000000, 24'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("done single cycle", 64'(done), 64'd0);
    check("quotient holds", 64'(quotient), 64'h000001000000);

    // 1.5 / 1.0
    launch(24'hC00000, 24'h800000);
    wait_done("three_halves", 48, 1'b0);
    check_result("three_halves", 48'h000001800000, 24'h0, 1'b0, 1'b0);

    // 1.0 / 1.5: inexact, leading one at bit 23
    launch(24'h800000, 24'hC00000);
    wait_done("two_thirds", 48, 1'b0);
    check_result("two_thirds", 48'h000000AAAAAA, 24'h800000, 1'b1, 1'b0);

    // 1.0 / (2 - ulp): quotient 2^23, remainder 2^23
    launch(24'h800000, 24'hFFFFFF);
    wait_done("max_divisor", 48, 1'b0);
    check_result("max_divisor", 48'h000000800000, 24'h800000, 1'b1, 1'b0);

    // Reset in the middle of a run
    launch(24'hC00000, 24'h800000);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check_result("abort", '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("abort no done", 64'(seen), 64'd0);

    // Fresh operation after the abort
    launch(24'hFFFFFF, 24'h800000);
    wait_done("after_abort", 48, 1'b0);
    check_result("after_abort", 48'h000001FFFFFE, 24'h0, 1'b0, 1'b0);

    // Divide by zero completes on the start edge
    launch(24'h900000, 24'h000000);
    check("dbz done", 64'(done), 64'd1);
    check("dbz busy", 64'(busy), 64'd0);
    check_result("dbz", 48'hFFFFFFFFFFFF, 24'h0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("dbz done single cycle", 64'(done), 64'd0);

    // Starts during RUN are ignored; operands stay latched
    launch(24'hC00000, 24'h800000);
    wait_done("ignored_starts", 48, 1'b1);
    check_result("ignored_starts", 48'h000001800000, 24'h0, 1'b0, 1'b0);

    // Back-to-back start in the done cycle
    launch(24'h800000, 24'hC00000);
    wait_done("back_to_back", 48, 1'b0);
    check_result("back_to_back", 48'h000000AAAAAA, 24'h800000, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
